// File: rtl/walk_request_bank_pkg.sv
// Shared definitions for the pedestrian walk-request bank.
// Holds the default channel count, age-counter width, urgency threshold and
// edge/level capture mode, plus a helper that advances a channel index
// modulo the channel count. The arbiter and the top both use that helper.
package walk_request_bank_pkg;

  localparam int DEF_N_CH          = 2;
  localparam int DEF_AGE_W         = 8;
  localparam int DEF_URGENT_CYCLES = 200;
  localparam int DEF_EDGE_MODE     = 1;

  // Next channel in round-robin order. Wraps from n_ch-1 back to 0.
  function automatic int next_chan(input int chan, input int n_ch);
    return (chan == n_ch - 1) ? 0 : chan + 1;
  endfunction

endpackage

// File: rtl/walk_request_bank_if.sv
// Service handshake between the walk-request bank and the phase FSM.
//   svc_valid : a request is offered (bank -> FSM)
//   svc_chan  : channel being offered (bank -> FSM)
//   svc_ready : FSM accepts the offered channel (FSM -> bank)
// Handshake rule: a transfer happens on every rising clk edge where
// svc_valid && svc_ready. While svc_valid is high and svc_ready is low, the
// offered svc_chan stays fixed until the transfer happens or the request is
// withdrawn by an external clear.
// Modports: master = the bank (offers), slave = the FSM (accepts).
interface walk_request_bank_if
  import walk_request_bank_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  localparam int CHAN_W = $clog2(N_CH)
) ();

  logic              svc_valid;
  logic              svc_ready;
  logic [CHAN_W-1:0] svc_chan;

  modport master (output svc_valid, output svc_chan, input  svc_ready);
  modport slave  (input  svc_valid, input  svc_chan, output svc_ready);

endinterface

// File: rtl/walk_request_bank_rr_arbiter.sv
// Combinational rotating-priority picker.
//   req       : request vector, one bit per channel
//   ptr       : channel that has highest priority this cycle
//   grant_idx : first requesting channel found scanning ptr, ptr+1, ... mod N_CH
//               (0 when nothing is requested)
//   any       : at least one request present
module walk_request_bank_rr_arbiter
  import walk_request_bank_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  localparam int CHAN_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]   req,
  input  logic [CHAN_W-1:0] ptr,
  output logic [CHAN_W-1:0] grant_idx,
  output logic              any
);

  always_comb begin
    int              idx;
    logic [N_CH-1:0] shifted;
    grant_idx = '0;
    any       = 1'b0;
    shifted   = '0;
    idx       = int'(ptr);
    for (int k = 0; k < N_CH; k++) begin
      // Shifting brings bit idx to position 0 without an over-wide index.
      shifted = req >> idx;
      if (!any && shifted[0]) begin
        any       = 1'b1;
        grant_idx = CHAN_W'(idx);
      end
      idx = next_chan(idx, N_CH);
    end
  end

endmodule

// File: rtl/walk_request_bank.sv
// N-channel pedestrian walk-request latch.
// Captures synchronised button inputs, holds each request until it is served
// or cleared, and ages pending requests. It offers one channel at a time to
// the phase FSM. Urgent requests go first; ties are broken round-robin.
// Ports:
//   clk, g_reset      : clock; synchronous active-high reset
//   wr_sync[N_CH]     : synchronised button levels
//   wr_clear[N_CH]    : per-channel external clear
//   wr_clear_all      : clear every request and age counter
//   svc               : service handshake (master side)
//   wr_out[N_CH]      : pending-request flags
//   wr_urgent[N_CH]   : pending and age >= URGENT_CYCLES
//   wr_any            : any request pending
//   dbg_rr_ptr, dbg_lock, dbg_lock_chan : internal arbitration state
module walk_request_bank
  import walk_request_bank_pkg::*;
#(
  parameter  int N_CH          = DEF_N_CH,
  parameter  int AGE_W         = DEF_AGE_W,
  parameter  int URGENT_CYCLES = DEF_URGENT_CYCLES,
  parameter  int EDGE_MODE     = DEF_EDGE_MODE,
  localparam int CHAN_W        = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                g_reset,
  input  logic [N_CH-1:0]     wr_sync,
  input  logic [N_CH-1:0]     wr_clear,
  input  logic                wr_clear_all,
  walk_request_bank_if.master svc,
  output logic [N_CH-1:0]     wr_out,
  output logic [N_CH-1:0]     wr_urgent,
  output logic                wr_any,
  output logic [CHAN_W-1:0]   dbg_rr_ptr,
  output logic                dbg_lock,
  output logic [CHAN_W-1:0]   dbg_lock_chan
);

  localparam logic [AGE_W-1:0] AGE_MAX    = '1;
  localparam logic [AGE_W-1:0] AGE_URGENT = AGE_W'(URGENT_CYCLES);

  logic [N_CH-1:0]   prev_sync, set_req, clr, cand;
  logic [AGE_W-1:0]  age [N_CH];
  logic [CHAN_W-1:0] rr_ptr, lock_chan, arb_chan, svc_chan_c;
  logic              lock, arb_any, svc_valid_c, hs;

  assign set_req = (EDGE_MODE != 0) ? (wr_sync & ~prev_sync) : wr_sync;

  always_comb begin
    wr_urgent = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_urgent[i] = wr_out[i] && (age[i] >= AGE_URGENT);
    end
  end

  // Urgent requests shadow the ordinary ones completely.
  assign cand = (|wr_urgent) ? wr_urgent : wr_out;

  walk_request_bank_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (cand),
    .ptr       (rr_ptr),
    .grant_idx (arb_chan),
    .any       (arb_any)
  );

  assign wr_any      = |wr_out;
  // arb_any equals wr_any: the candidate set is non-empty exactly when
  // something is pending.
  assign svc_valid_c = lock | arb_any;
  assign svc_chan_c  = lock ? lock_chan : arb_chan;
  assign hs          = svc_valid_c & svc.svc_ready;

  assign svc.svc_valid = svc_valid_c;
  assign svc.svc_chan  = svc_chan_c;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr[i] = wr_clear_all | wr_clear[i] | (hs && (svc_chan_c == CHAN_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    // The edge detector keeps tracking the button levels during reset. A
    // button held across reset then does not raise a request on release.
    prev_sync <= wr_sync;
    if (g_reset) begin
      wr_out    <= '0;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_chan <= '0;
      for (int i = 0; i < N_CH; i++) age[i] <= '0;
    end else begin
      wr_out <= ~clr & (wr_out | set_req);
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i] || !wr_out[i]) age[i] <= '0;
        else if (age[i] != AGE_MAX) age[i] <= age[i] + AGE_W'(1);
      end
      if (hs) begin
        lock   <= 1'b0;
        rr_ptr <= CHAN_W'(next_chan(int'(svc_chan_c), N_CH));
      end else if (lock) begin
        // The held channel was withdrawn externally, so re-arbitrate.
        if (clr[lock_chan]) lock <= 1'b0;
      end else if (svc_valid_c && !clr[svc_chan_c]) begin
        // The offer was not taken. Freeze the channel until it is.
        lock      <= 1'b1;
        lock_chan <= svc_chan_c;
      end
    end
  end

  assign dbg_rr_ptr    = rr_ptr;
  assign dbg_lock      = lock;
  assign dbg_lock_chan = lock_chan;

endmodule
